// File: rtl/serial_shift_scheduler.sv
// Round-robin scheduler sharing one MSB-first serial shift channel between two
// parallel-word requesters; each frame is WIDTH sen cycles followed by a done gap.
module serial_shift_scheduler #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sen,
  output logic             busy,
  output logic             done,
  output logic             gnt_id
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             gnt_id_q, gnt_id_d;
  logic             sel1;

  // Requester 1 wins when it is alone, or when both are valid and it is its turn.
  assign sel1 = req1_valid && (!req0_valid || rr_ptr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= 1'b0;
      gnt_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = !rst && req0_valid && !sel1;
        req1_ready = !rst && sel1;
        if (req0_ready || req1_ready) begin
          shreg_d  = sel1 ? req1_data : req0_data;
          cnt_d    = '0;
          gnt_id_d = sel1;
          rr_ptr_d = !sel1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        // Abort wins over the final-bit transition, so a cut frame never reaches GAP.
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sen    = (state_q == SHIFT);
  assign sout   = sen && shreg_q[WIDTH-1];
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == GAP);
  assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_serial_shift_scheduler.sv
// Scoreboard bench: a transaction-level model predicts grants, frame timing and bit
// streams; negedge monitors pop and compare whenever the scheduler shows a handshake.
module tb_serial_shift_scheduler;

  localparam int unsigned W     = 8;
  localparam int          N_CYC = 4000;
  localparam int          DRAIN = 16;

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          nbits;
    bit          done_exp;
    bit          cut;
    int          start;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, v0, v1, abort, r0, r1, sout, sen, busy, done, gnt_id;
  logic [W-1:0] d0, d1;
  logic         rst2, v20, v21, abort2, r20, r21, sout2, sen2, busy2, done2, gnt2;
  logic [1:0]   d20, d21;

  int checks = 0;
  int errors = 0;
  int tick   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at tick %0d", nm, act, expv, tick);
    end
  endtask

  serial_shift_scheduler #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
    .abort(abort), .sout(sout), .sen(sen), .busy(busy), .done(done), .gnt_id(gnt_id)
  );

  serial_shift_scheduler #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst2),
    .req0_valid(v20), .req0_data(d20), .req0_ready(r20),
    .req1_valid(v21), .req1_data(d21), .req1_ready(r21),
    .abort(abort2), .sout(sout2), .sen(sen2), .busy(busy2), .done(done2), .gnt_id(gnt2)
  );

  // Main monitor: collect each frame's bits and compare against the popped expectation.
  exp_t        exp_q[$];
  exp_t        cur;
  bit          in_frame  = 1'b0;
  bit          after_rst = 1'b0;
  int          nb;
  logic [31:0] bits;

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (after_rst) begin
        chk("post_rst_outputs", {sen, sout, busy, done, gnt_id}, 0);
        after_rst = 1'b0;
      end
      chk("ready_onehot", r0 & r1, 0);
      if (!sen) chk("sout_when_idle", sout, 0);
      if (in_frame && sen) begin
        bits = (bits << 1) | {31'd0, sout};
        nb++;
        chk("done_during_shift", done, 0);
      end else if (in_frame) begin
        chk("frame_nbits", nb, cur.nbits);
        chk("frame_bits", bits, cur.data >> (W - cur.nbits));
        chk("frame_done", done, cur.done_exp);
        chk("frame_busy_end", busy, cur.done_exp);
        chk("frame_gnt_id", gnt_id, cur.id);
        chk("frame_end_tick", tick, cur.start + cur.nbits + 1);
        in_frame = 1'b0;
      end else begin
        chk("done_outside_frame", done, 0);
      end
      if (r0 || r1) begin
        chk("hs_sen_low", sen, 0);
        chk("hs_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("hs_id", r1, cur.id);
          chk("hs_tick", tick, cur.start);
          in_frame = 1'b1;
          nb       = 0;
          bits     = '0;
        end
      end
    end
  end

  // WIDTH=2 monitor.
  logic [1:0]  w2_q[$];
  logic [1:0]  w2_cur;
  bit          w2_in = 1'b0;
  int          w2_nb;
  logic [31:0] w2_bits;

  always @(negedge clk) begin
    if (!rst2) begin
      if (w2_in && sen2) begin
        w2_bits = (w2_bits << 1) | {31'd0, sout2};
        w2_nb++;
      end else if (w2_in) begin
        chk("w2_nbits", w2_nb, 2);
        chk("w2_bits", w2_bits, {30'd0, w2_cur});
        chk("w2_done", done2, 1);
        w2_in = 1'b0;
      end
      if (r20) begin
        chk("w2_hs_expected", w2_q.size() > 0, 1);
        if (w2_q.size() > 0) w2_cur = w2_q.pop_front();
        w2_in   = 1'b1;
        w2_nb   = 0;
        w2_bits = '0;
      end
    end
  end

  // Directed phases by frame index, then random traffic.
  function automatic bit want(input bit n, input int f);
    if (f == 0) return !n;
    if (f <= 2) return n;
    if (f <= 7) return 1'b1;
    return $urandom_range(2) == 0;
  endfunction

  function automatic logic [W-1:0] word(input bit n, input int f);
    if (f == 0) return W'(8'hA5);
    if (f <= 2) return W'(8'h81);
    if (f <= 4) return W'(8'hFF);
    if (f <= 7) return n ? W'(8'h0F) : W'(8'hF0);
    return W'($urandom);
  endfunction

  task automatic pick_fate(input int f, output int ak, output int rk);
    int r;
    ak = 0;
    rk = 0;
    if (f == 3) ak = 4;
    else if (f == 4) rk = 5;
    else if (f >= 8) begin
      r = $urandom_range(9);
      if (r <= 1) ak = $urandom_range(W, 1);
      else if (r == 2) rk = $urandom_range(W, 1);
    end
  endtask

  task automatic run_main();
    int   frames    = 0;
    int   h         = -100;
    int   idle_at   = 0;
    int   shift_end = -1;
    int   rst_cyc   = -100;
    int   ak        = 0;
    int   rk        = 0;
    int   c;
    bit   rr        = 1'b0;
    bit   hs0       = 1'b0;
    bit   hs1       = 1'b0;
    bit   w;
    exp_t e;
    for (int n = 0; n < N_CYC; n++) begin
      @(posedge clk); #1;
      c     = tick;
      rst   = 1'b0;
      abort = 1'b0;
      if (hs0) v0 = 1'b0;
      if (hs1) v1 = 1'b0;
      hs0 = 1'b0;
      hs1 = 1'b0;
      if (c == rst_cyc || c == rst_cyc + 1 || n >= N_CYC - DRAIN) begin
        v0 = 1'b0;
        v1 = 1'b0;
        if (c == rst_cyc) rst = 1'b1;
      end else if (c == rst_cyc + 2) begin
        v0 = 1'b1; d0 = word(1'b0, frames);
        v1 = 1'b1; d1 = word(1'b1, frames);
      end else begin
        if (!v0 && want(1'b0, frames)) begin v0 = 1'b1; d0 = word(1'b0, frames); end
        if (!v1 && want(1'b1, frames)) begin v1 = 1'b1; d1 = word(1'b1, frames); end
      end
      if (c > h && c <= shift_end) abort = (c == h + ak);
      else abort = ($urandom_range(3) == 0);
      if (rst) rr = 1'b0;
      if (!rst && c >= idle_at && (v0 || v1)) begin
        w   = (v0 && v1) ? rr : v1;
        rr  = !w;
        h   = c;
        hs0 = !w;
        hs1 = w;
        pick_fate(frames, ak, rk);
        e.id    = w;
        e.data  = w ? 32'(d1) : 32'(d0);
        e.start = c;
        e.cut   = 1'b0;
        if (ak != 0) begin
          e.nbits = ak; e.done_exp = 1'b0; shift_end = c + ak; idle_at = c + ak + 1;
        end else if (rk != 0) begin
          e.nbits = rk; e.done_exp = 1'b0; e.cut = 1'b1;
          rst_cyc = c + rk; shift_end = c + rk; idle_at = c + rk + 1;
        end else begin
          e.nbits = W; e.done_exp = 1'b1; shift_end = c + W; idle_at = c + W + 2;
        end
        exp_q.push_back(e);
        frames++;
      end
    end
  endtask

  task automatic run_w2();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      v20 = 1'b1;
      d20 = (i == 0) ? 2'b10 : 2'($urandom);
      w2_q.push_back(d20);
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (r20) break;
      end
      chk("w2_ready_seen", r20, 1);
      @(posedge clk); #1;
      v20 = 1'b0;
      repeat (2) @(posedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; abort = 1'b0;
    v20 = 1'b0; v21 = 1'b0; d20 = '0; d21 = '0; abort2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst2 = 1'b0;
    fork
      run_main();
      run_w2();
    join
    repeat (3) @(negedge clk);
    chk("end_not_in_frame", in_frame, 0);
    chk("end_queue_empty", exp_q.size(), 0);
    chk("w2_end_queue_empty", w2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_shift_scheduler.md
Name: serial_shift_scheduler

Overview:
- Shares one serial shift channel between two parallel-word requesters (req0, req1) using round-robin arbitration.
- Accepts a WIDTH-bit word via a valid/ready handshake and serializes it MSB-first onto sout with a qualifying sen strobe.
- Signals frame completion with a one-cycle done pulse.
- Sits upstream of the team's serial-in shift-register receivers and sequences what they shift in.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32. The bit counter is $clog2(WIDTH) bits wide.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- req0_valid  input  1  requester 0 has a word to send
- req0_data  input  WIDTH  requester 0 word; sampled only on an accepted handshake
- req0_ready  output  1  scheduler accepts requester 0 this cycle (combinational)
- req1_valid  input  1  requester 1 has a word to send
- req1_data  input  WIDTH  requester 1 word
- req1_ready  output  1  scheduler accepts requester 1 this cycle (combinational)
- abort  input  1  terminate the frame in progress
- sout  output  1  serial data, MSB first; 0 when sen=0
- sen  output  1  sout carries a valid bit this cycle
- busy  output  1  high whenever the state is not IDLE
- done  output  1  one-cycle pulse after the last bit of a completed frame
- gnt_id  output  1  requester owning the current or most recent frame

Behaviour:
- States: IDLE, SHIFT, GAP.
- Reset values: state=IDLE, shreg=0, cnt=0, rr_ptr=0, gnt_id=0; sout=0, sen=0, busy=0, done=0, req0_ready=0, req1_ready=0.
- rst overrides everything, including a frame in progress. No done is raised for a frame cut short by rst.
- Arbitration happens only in IDLE:
  - If only one requester is valid, it is selected.
  - If both are valid, the requester matching rr_ptr is selected.
  - reqN_ready = (state==IDLE) && reqN_valid && selected. At most one ready is high in any cycle.
  - Ready is never high in SHIFT or GAP.
- Handshake: a transfer occurs at the clock edge where reqN_valid && reqN_ready. At that edge:
  - shreg <= reqN_data, cnt <= 0, gnt_id <= N, rr_ptr <= ~N, state <= SHIFT.
  - reqN_valid must stay high until ready; this block does not check that.
- SHIFT:
  - sen=1 and sout=shreg[WIDTH-1] (combinational from state and shreg).
  - Each edge: shreg shifts left with 0 fill, cnt increments.
  - At the edge where cnt==WIDTH-1, state goes to GAP.
  - sen is high for exactly WIDTH consecutive cycles.
  - The first bit appears in the cycle after the handshake edge.
- GAP: done=1 for one cycle, sen=0, then IDLE on the next edge.
- Minimum frame-to-frame spacing is WIDTH+2 cycles: one IDLE (handshake) cycle, WIDTH SHIFT cycles, one GAP cycle.
- Abort:
  - If abort=1 at an edge in SHIFT, state goes to IDLE.
  - done is not asserted, and sen drops in the next cycle.
  - rr_ptr is not restored; it has already advanced past the aborted requester.
  - abort is ignored in IDLE and GAP.
  - abort on the final bit's edge still goes to IDLE with no done.
- busy=1 in SHIFT and GAP. done is asserted only in GAP.
- Data is not buffered: a requester whose valid is high while busy waits with ready=0.

Test Plan:
- Single frame: after reset, req0_valid=1, req0_data=8'hA5.
  - Expect: req0_ready=1 in cycle 0; sen high cycles 1-8 with sout=1,0,1,0,0,1,0,1; done=1 in cycle 9; busy low from cycle 10; gnt_id=0.
- Contention: req0 and req1 both valid continuously with data 8'hF0 and 8'h0F.
  - Expect: frames granted in order req0, req1, req0 (gnt_id 0,1,0); bit streams 11110000, then 00001111; each handshake exactly 10 cycles apart.
- Lone requester: only req1_valid held high with 8'h81 for two frames.
  - Expect: both frames granted to req1 despite rr_ptr; sout=10000001 twice.
- Abort: abort=1 during the 4th sen cycle of an 8'hFF frame.
  - Expect: sen low from the next cycle; no done pulse; IDLE; the next grant goes to the other requester if both are valid.
- Reset mid-frame: rst=1 during the 5th SHIFT cycle.
  - Expect: in the next cycle all outputs are 0 and no done pulse; rr_ptr=0, so requester 0 wins the next contention.
- WIDTH=2: req0_data=2'b10.
  - Expect: sen for exactly 2 cycles with sout=1,0; done in the following cycle.
